// File: rtl/prefetch_queue.sv
// ----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch queue for an 8086-style bus interface unit. It is a byte
// FIFO that sits between the bus fetch path and the execution-unit decoder.
//
//   * The bus side pushes 16-bit little-endian fetch words. A word fetched from
//     an even address contributes both bytes, low byte first. A fetch that
//     started at an odd address contributes only the high byte.
//   * The EU side pops one byte per valid/ready handshake.
//   * flush empties the queue so that fetching can restart at a new CS:IP
//     after a control transfer.
//
// Storage is a DEPTH x 8 register array addressed by head/tail pointers. The
// pointers wrap with an explicit compare, so DEPTH does not have to be a power
// of two. A byte count register tells a full queue apart from an empty one
// when head == tail.
//
// wr_ready only promises room for a complete 2-byte word. It is computed from
// the registered count, so a pop in the same cycle cannot raise it. This keeps
// the ready path short and free of any dependency on the EU side.
// ----------------------------------------------------------------------------
module prefetch_queue #(
    parameter int DEPTH = 6,   // capacity in bytes, >= 2
    parameter int CNT_W = 3    // width of count, must be able to hold DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [15:0]      wr_data,
    input  logic             wr_odd,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Last valid slot index. A pointer at this value wraps back to slot 0.
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Count value of a completely full queue.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Highest count at which a full 2-byte word still fits.
    localparam logic [CNT_W-1:0] CNT_WR_MAX = CNT_W'(DEPTH - 2);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Advance a slot pointer by one. It wraps at DEPTH-1 rather than at a
    // power-of-two boundary.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Number of bytes between head and tail, modulo DEPTH. A full queue also
    // has head == tail, so this returns 0 in that case. The count register
    // resolves that ambiguity.
    function automatic int ptr_span(input logic [PTR_W-1:0] head,
                                    input logic [PTR_W-1:0] tail);
        int span;
        span = int'(tail) - int'(head);
        if (span < 0) begin
            span = span + DEPTH;
        end
        return span;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic             push_en;    // a fetch word is accepted this cycle
    logic             pop_en;     // the head byte is consumed this cycle
    logic [PTR_W-1:0] tail_p1;    // slot after tail, used by the second byte
    logic [PTR_W-1:0] tail_p2;    // tail after pushing a full word
    logic [CNT_W-1:0] push_cnt;   // bytes added this cycle: 0, 1 or 2
    logic [CNT_W-1:0] pop_cnt;    // bytes removed this cycle: 0 or 1

    // Ready/valid flags and the head byte, all taken from registered state.
    always_comb begin
        wr_ready = (count_q <= CNT_WR_MAX) && !flush;
        rd_valid = (count_q != '0);
        // Slots that were never written, or that hold stale data, are never
        // shown. An empty queue always presents 8'h00.
        rd_data  = rd_valid ? mem_q[head_q] : 8'h00;
    end

    // Decide what is accepted this cycle and where the tail lands.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front.
        // A path that leaves one unassigned infers a latch.
        push_en  = 1'b0;
        pop_en   = 1'b0;
        push_cnt = '0;
        pop_cnt  = '0;
        tail_p1  = ptr_inc(tail_q);
        tail_p2  = ptr_inc(tail_p1);

        // wr_ready already contains !flush, so a flush cycle never pushes.
        if (wr_valid && wr_ready) begin
            push_en  = 1'b1;
            push_cnt = wr_odd ? CNT_W'(1) : CNT_W'(2);
        end

        // During a flush, a pop has no effect beyond the clear.
        if (rd_valid && rd_ready && !flush) begin
            pop_en  = 1'b1;
            pop_cnt = CNT_W'(1);
        end
    end

    // Next-state for the pointers and count. flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_en) begin
                head_d = ptr_inc(head_q);
            end
            if (push_en) begin
                tail_d = wr_odd ? tail_p1 : tail_p2;
            end
            // Push and pop can happen in the same cycle. Both are applied
            // here, so the count always equals the number of bytes held.
            count_d = count_q + push_cnt - pop_cnt;
        end
    end

    // Register pointers and count. An asynchronous reset clears them at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments. Every flop then
        // samples pre-edge values, whatever order the blocks are evaluated in.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write accepted fetch bytes into the array at tail and tail+1.
    always_ff @(posedge clk) begin
        // NOTE: the byte array is deliberately left out of reset. rd_data is
        // gated by rd_valid, so its contents can never leak out, and leaving
        // it unreset lets it map onto plain enable flops.
        if (push_en) begin
            if (wr_odd) begin
                // Odd-address fetch: only the high byte belongs to the
                // instruction stream.
                mem_q[tail_q]  <= wr_data[15:8];
            end else begin
                // Little-endian word: the even-address byte goes first. The
                // second slot wraps with the pointer, so a word straddling
                // DEPTH-1 -> 0 still occupies consecutive slots.
                mem_q[tail_q]  <= wr_data[7:0];
                mem_q[tail_p1] <= wr_data[15:8];
            end
        end
    end

    assign count = count_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------

    // The count never exceeds the physical capacity.
    count_in_range_a : assert property (
        @(posedge clk) disable iff (reset)
        count_q <= CNT_FULL
    );

    // The count agrees with the head/tail distance. A full queue is the one
    // case where head == tail while bytes are held.
    count_matches_ptrs_a : assert property (
        @(posedge clk) disable iff (reset)
        (count_q == CNT_FULL) ? (head_q == tail_q)
                              : (ptr_span(head_q, tail_q) == int'(count_q))
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_prefetch_queue
//
// Self-checking bench for prefetch_queue. A byte queue in the bench models the
// FIFO. Every cycle the DUT outputs are compared with what that model implies.
// Directed sequences add explicit literal expectations, and randomized traffic
// exercises wraparound, push and pop together, flush and mid-run reset.
// ----------------------------------------------------------------------------
module tb_prefetch_queue;

    localparam int DEPTH = 6;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             wr_valid;
    logic [15:0]      wr_data;
    logic             wr_odd;
    logic             wr_ready;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_ready;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bytes currently held, oldest first.
    byte unsigned model_q[$];

    prefetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_odd   (wr_odd),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs with the model state and the inputs now driven.
    task automatic check_model(input string tag);
        int unsigned sz;
        sz = model_q.size();
        check({tag, ".count"},    32'(count),    32'(sz));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(sz != 0));
        check({tag, ".rd_data"},  32'(rd_data),  (sz != 0) ? 32'(model_q[0]) : 32'h0);
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'((sz <= DEPTH - 2) && !flush));
    endtask

    // Apply one cycle of stimulus. The inputs are driven at negedge and the
    // outputs checked 1ns later. At the next posedge the model advances, and
    // 1ns after that the inputs go back to idle.
    task automatic step(input logic wv, input logic [15:0] wd, input logic wo,
                        input logic rr, input logic fl, input string tag);
        bit acc;
        bit pop;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        wr_odd   = wo;
        rd_ready = rr;
        flush    = fl;
        #1;
        check_model(tag);
        acc = wv && !fl && (model_q.size() <= DEPTH - 2);
        pop = rr && !fl && (model_q.size() != 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) begin
                if (!wo) model_q.push_back(wd[7:0]);
                model_q.push_back(wd[15:8]);
            end
        end
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        wr_odd   = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] wd, input logic wo);
        step(1'b1, wd, wo, 1'b0, 1'b0, "push");
    endtask

    // Check the head byte against a literal, then pop it.
    task automatic pop_expect(input logic [7:0] exp, input string tag);
        check(tag, 32'(rd_data), 32'(exp));
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, tag);
    endtask

    task automatic random_run(input int cycles, input int flush_pct, input string tag);
        for (int i = 0; i < cycles; i++) begin
            step(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < flush_pct), tag);
        end
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0;
        wr_odd   = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then idle.
        #1;
        check("rst.count",    32'(count),    32'd0);
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.wr_ready", 32'(wr_ready), 32'd1);
        check("rst.rd_data",  32'(rd_data),  32'h00);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "idle");

        // Two even words; the bytes come out little-endian in push order.
        push_word(16'hB890, 1'b0);
        check("two.cnt2", 32'(count), 32'd2);
        push_word(16'h3412, 1'b0);
        check("two.cnt4", 32'(count), 32'd4);
        pop_expect(8'h90, "two.p0");
        pop_expect(8'hB8, "two.p1");
        pop_expect(8'h12, "two.p2");
        pop_expect(8'h34, "two.p3");
        check("two.empty", 32'(rd_valid), 32'd0);

        // Fill with three words: count 6, no room, and a further push is dropped.
        push_word(16'h0201, 1'b0);
        push_word(16'h0403, 1'b0);
        push_word(16'h0605, 1'b0);
        check("full.cnt",   32'(count),    32'd6);
        check("full.ready", 32'(wr_ready), 32'd0);
        push_word(16'hAAAA, 1'b0);
        check("full.drop",  32'(count),    32'd6);
        pop_expect(8'h01, "full.p0");
        check("cnt5.ready", 32'(wr_ready), 32'd0);
        for (int i = 2; i <= 6; i++) pop_expect(8'(i), "full.pn");
        check("full.empty", 32'(rd_valid), 32'd0);

        // Odd-address start pushes only the high byte.
        push_word(16'hCD5A, 1'b1);
        check("odd.cnt",  32'(count),   32'd1);
        check("odd.data", 32'(rd_data), 32'hCD);
        push_word(16'h2211, 1'b0);
        pop_expect(8'hCD, "odd.p0");
        pop_expect(8'h11, "odd.p1");
        pop_expect(8'h22, "odd.p2");

        // Random traffic without flush: wraparound, plus push and pop together.
        random_run(50, 0, "rnd");

        // Flush at count 4 with a write and a pop requested in the same cycle.
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, "pre_flush");
        push_word(16'h1357, 1'b0);
        push_word(16'h2468, 1'b0);
        check("fl.cnt4", 32'(count), 32'd4);
        step(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, "flush");
        check("fl.cnt",   32'(count),    32'd0);
        check("fl.valid", 32'(rd_valid), 32'd0);
        push_word(16'hEEFF, 1'b0);
        pop_expect(8'hFF, "fl.p0");
        pop_expect(8'hEE, "fl.p1");

        // Longer random traffic with occasional flushes.
        random_run(300, 5, "rndf");

        // Asynchronous reset in the middle of operation clears the queue at once.
        push_word(16'h7788, 1'b0);
        reset = 1'b1;
        #1;
        check("arst.count",    32'(count),    32'd0);
        check("arst.rd_valid", 32'(rd_valid), 32'd0);
        check("arst.rd_data",  32'(rd_data),  32'h00);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
        push_word(16'hA1B2, 1'b0);
        pop_expect(8'hB2, "arst.p0");
        pop_expect(8'hA1, "arst.p1");
        random_run(60, 3, "rnd2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
